// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and aluControl.
//   ALUctrl operation codes, FSM state encoding, and a decode helper.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_ADDR = 4'b0110;  // lw/sw address add

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } alu_state_t;

    // True for the codes that run through the iterative datapath.
    function automatic logic is_multicycle(input logic [3:0] ctrl);
        return (ctrl == ALU_MUL) || (ctrl == ALU_DIV);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider core, one quotient bit per step.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_start      : load dividend/divisor, clear partial remainder
//   i_step       : perform one restoring step this cycle
//   i_cnt        : iteration counter owned by the caller (steps remaining)
//   i_dividend   : unsigned dividend
//   i_divisor    : unsigned divisor (non-zero)
//   o_quot/o_rem : unsigned quotient / remainder, valid after the last step
//   o_done       : high during the final step
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_done
);

    logic [WIDTH-1:0] r_quot;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    // Remainder stays below the divisor (<= 2^(WIDTH-1)), so the shifted
    // value fits WIDTH bits and bit WIDTH of the trial is a clean borrow.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
        end else if (i_start) begin
            r_quot <= i_dividend;
            r_rem  <= '0;
            r_dvs  <= i_divisor;
        end else if (i_step) begin
            if (!w_trial[WIDTH]) begin
                r_rem  <= w_trial[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b1};
            end else begin
                r_rem  <= w_shift[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_done = i_step && (i_cnt == CNT_W'(1));

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle add/sub/and/or plus iterative signed
// multiply (shift-add) and signed divide (restoring, via seq_divider).
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : request, honoured only in IDLE
//   ALUctrl      : operation code from aluControl
//   a, b         : signed operands, latched at start
//   result       : sum/diff/logic, product low half, or quotient
//   result_hi    : product high half or remainder; 0 for single-cycle ops
//   zero         : result == 0
//   overflow     : signed overflow of add/sub
//   div_by_zero  : divide issued with b == 0
//   busy         : iterative op in flight, stall request
//   done         : one-cycle pulse, outputs valid
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    alu_state_t r_state, w_state_nx;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mcand;      // |a| for multiply
    logic [2*WIDTH:0]   r_prod;       // {carry, high acc, multiplier/low product}
    logic               r_neg;        // product sign or quotient sign
    logic               r_rem_neg;    // remainder takes the dividend sign
    logic               r_is_div;
    logic               r_div0;
    logic [WIDTH-1:0]   r_dz_a;       // dividend echoed back on divide-by-zero

    logic [WIDTH-1:0]   r_result, r_result_hi;
    logic               r_zero, r_ov, r_dbz, r_done;

    logic               w_busy;
    logic               w_accept;
    logic               w_is_mul, w_is_div, w_single, w_b_zero;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH-1:0]   w_sum, w_diff;
    logic [WIDTH-1:0]   w_sc_res;
    logic               w_sc_ov;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quot, w_rem, w_quot_s, w_rem_s;
    logic               w_div_start, w_div_step, w_div_done;

    // ---------------- decode / operand conditioning ----------------
    assign w_is_mul = (ALUctrl == ALU_MUL);
    assign w_is_div = (ALUctrl == ALU_DIV);
    assign w_single = !is_multicycle(ALUctrl);
    assign w_b_zero = (b == '0);
    assign w_accept = start && (r_state == ST_IDLE);

    // Magnitudes as unsigned; the most-negative value maps to 2^(WIDTH-1).
    assign w_abs_a = a[WIDTH-1] ? ('0 - a) : a;
    assign w_abs_b = b[WIDTH-1] ? ('0 - b) : b;

    assign w_sum  = a + b;
    assign w_diff = a - b;

    always_comb begin
        w_sc_res = w_sum;
        w_sc_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        case (ALUctrl)
            ALU_SUB: begin
                w_sc_res = w_diff;
                w_sc_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: begin
                w_sc_res = a & b;
                w_sc_ov  = 1'b0;
            end
            ALU_OR: begin
                w_sc_res = a | b;
                w_sc_ov  = 1'b0;
            end
            default: ;  // add, address add and reserved codes
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    // Divide-by-zero passes through FIX so it shares the writeback edge
    // with the iterative ops, giving it a two-cycle latency.
    always_comb begin
        w_state_nx = r_state;
        w_busy     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && w_is_mul)      w_state_nx = ST_MUL;
                else if (start && w_is_div) w_state_nx = w_b_zero ? ST_FIX : ST_DIV;
            end
            ST_MUL: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_W'(1)) w_state_nx = ST_FIX;
            end
            ST_DIV: begin
                w_busy = 1'b1;
                if (w_div_done) w_state_nx = ST_FIX;
            end
            ST_FIX: begin
                w_busy     = 1'b1;
                w_state_nx = ST_DONE;
            end
            ST_DONE:  w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    // ---------------- iterative datapath ----------------
    // Shift-add: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    assign w_mul_sum = r_prod[2*WIDTH:WIDTH] + (r_prod[0] ? {1'b0, r_mcand} : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_prod    <= '0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_is_div  <= 1'b0;
            r_div0    <= 1'b0;
            r_dz_a    <= '0;
        end else begin
            if (w_accept && !w_single) begin
                r_cnt     <= CNT_W'(WIDTH);
                r_neg     <= a[WIDTH-1] ^ b[WIDTH-1];
                r_rem_neg <= a[WIDTH-1];
                r_is_div  <= w_is_div;
                r_div0    <= w_is_div && w_b_zero;
                r_dz_a    <= a;
                if (w_is_mul) begin
                    r_mcand <= w_abs_a;
                    r_prod  <= {{(WIDTH+1){1'b0}}, w_abs_b};
                end
            end else if (r_state == ST_MUL) begin
                r_cnt  <= r_cnt - CNT_W'(1);
                r_prod <= {1'b0, w_mul_sum, r_prod[WIDTH-1:1]};
            end else if (r_state == ST_DIV) begin
                r_cnt  <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign w_div_start = w_accept && w_is_div && !w_b_zero;
    assign w_div_step  = (r_state == ST_DIV);

    seq_divider #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_step     (w_div_step),
        .i_cnt      (r_cnt),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_done     (w_div_done)
    );

    // Sign fix-up. Negating 2^(WIDTH-1) wraps back to itself, which is the
    // intended result for MIN / -1.
    assign w_prod_s = r_neg     ? ('0 - r_prod[2*WIDTH-1:0]) : r_prod[2*WIDTH-1:0];
    assign w_quot_s = r_neg     ? ('0 - w_quot) : w_quot;
    assign w_rem_s  = r_rem_neg ? ('0 - w_rem)  : w_rem;

    // ---------------- output registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_ov        <= 1'b0;
            r_dbz       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept && w_single) begin
                r_result    <= w_sc_res;
                r_result_hi <= '0;
                r_zero      <= (w_sc_res == '0);
                r_ov        <= w_sc_ov;
                r_dbz       <= 1'b0;
                r_done      <= 1'b1;
            end else if (r_state == ST_FIX) begin
                r_ov   <= 1'b0;
                r_done <= 1'b1;
                if (r_div0) begin
                    r_result    <= '1;
                    r_result_hi <= r_dz_a;
                    r_zero      <= 1'b0;
                    r_dbz       <= 1'b1;
                end else if (r_is_div) begin
                    r_result    <= w_quot_s;
                    r_result_hi <= w_rem_s;
                    r_zero      <= (w_quot_s == '0);
                    r_dbz       <= 1'b0;
                end else begin
                    r_result    <= w_prod_s[WIDTH-1:0];
                    r_result_hi <= w_prod_s[2*WIDTH-1:WIDTH];
                    r_zero      <= (w_prod_s[WIDTH-1:0] == '0);
                    r_dbz       <= 1'b0;
                end
            end
        end
    end

    assign result      = r_result;
    assign result_hi   = r_result_hi;
    assign zero        = r_zero;
    assign overflow    = r_ov;
    assign div_by_zero = r_dbz;
    assign busy        = w_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   ALUctrl = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result, result_hi;
    logic         zero, overflow, div_by_zero, busy, done;

    int n_chk = 0;
    int n_fail = 0;

    multicycle_alu #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUctrl(ALUctrl),
        .a(a), .b(b), .result(result), .result_hi(result_hi), .zero(zero),
        .overflow(overflow), .div_by_zero(div_by_zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed integer arithmetic on the spec's rules.
    function automatic void model(input logic [3:0] c, input logic [15:0] xa, input logic [15:0] xb,
                                  output logic [15:0] r, output logic [15:0] rh,
                                  output logic z, output logic ov, output logic dz, output int lat);
        longint sa, sb, s, m;
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        rh = 16'h0; ov = 1'b0; dz = 1'b0; lat = 1;
        case (c)
            4'd1: begin s = sa - sb; r = s[15:0]; ov = (s > 32767) || (s < -32768); end
            4'd2: begin s = sa * sb; r = s[15:0]; rh = s[31:16]; lat = W + 2; end
            4'd3: begin
                if (xb == 16'h0) begin
                    r = 16'hFFFF; rh = xa; dz = 1'b1; lat = 2;
                end else begin
                    s = sa / sb; m = sa % sb;
                    r = s[15:0]; rh = m[15:0]; lat = W + 2;
                end
            end
            4'd4: r = xa & xb;
            4'd5: r = xa | xb;
            default: begin s = sa + sb; r = s[15:0]; ov = (s > 32767) || (s < -32768); end
        endcase
        z = (r == 16'h0);
    endfunction

    task automatic op(input logic [3:0] c, input logic [15:0] xa, input logic [15:0] xb,
                      input bit inject, input string tag);
        logic [15:0] er, eh;
        logic ez, eo, ed;
        int el, lat, nb;
        model(c, xa, xb, er, eh, ez, eo, ed, el);
        @(negedge clk);
        ALUctrl = c; a = xa; b = xb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); ALUctrl = 4'($urandom);
        lat = 1; nb = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            lat++;
            start = (inject && lat == 3);
        end
        start = 1'b0;
        check({tag, ".timeout"}, 64'(lat < 40), 64'd1);
        check({tag, ".lat"}, 64'(lat), 64'(el));
        check({tag, ".res"}, 64'(result), 64'(er));
        check({tag, ".hi"}, 64'(result_hi), 64'(eh));
        check({tag, ".zero"}, 64'(zero), 64'(ez));
        check({tag, ".ovf"}, 64'(overflow), 64'(eo));
        check({tag, ".dbz"}, 64'(div_by_zero), 64'(ed));
        check({tag, ".busy_dn"}, 64'(busy), 64'd0);
        if (el == 1)      check({tag, ".busycyc"}, 64'(nb), 64'd0);
        else if (el > 2)  check({tag, ".busycyc"}, 64'(nb), 64'(W + 1));
        @(negedge clk);
        check({tag, ".pulse"}, 64'(done), 64'd0);
        check({tag, ".hold"}, 64'(result), 64'(er));
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h7FFF;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bit saw;
        repeat (2) @(negedge clk);
        check("rst.result", 64'(result), 64'd0);
        check("rst.hi", 64'(result_hi), 64'd0);
        check("rst.flags", 64'({zero, overflow, div_by_zero}), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        rst_n = 1'b1;

        op(4'h0, 16'h7FFF, 16'h0001, 0, "add_ovf");
        op(4'h1, 16'd5,    16'd5,    0, "sub_zero");
        op(4'h4, 16'hF0F0, 16'h0FF0, 0, "and");
        op(4'h5, 16'hF0F0, 16'h0FF0, 0, "or");
        op(4'h6, 16'h1000, 16'h0234, 0, "addr");
        op(4'hA, 16'h8000, 16'hFFFF, 0, "rsvd_add");
        op(4'h2, 16'hFFFD, 16'd7,    1, "mul_neg");
        op(4'h2, 16'h8000, 16'h8000, 0, "mul_min");
        op(4'h3, 16'hFFF9, 16'd2,    1, "div_neg");
        op(4'h3, 16'h8000, 16'hFFFF, 0, "div_min");
        op(4'h3, 16'h1234, 16'h0000, 0, "div0");

        // Abort an in-flight divide with reset; an add issued while busy is ignored.
        @(negedge clk);
        ALUctrl = 4'h3; a = 16'd100; b = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw = 1'b0;
        for (int cyc = 2; cyc < 8; cyc++) begin
            if (cyc == 3) begin ALUctrl = 4'h0; a = 16'd1; b = 16'd2; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            saw |= done;
        end
        start = 1'b0;
        check("abort.nodone", 64'(saw), 64'd0);
        check("abort.busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.result", 64'(result), 64'd0);
        check("abort.hi", 64'(result_hi), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort.done2", 64'(done), 64'd0);
        op(4'h0, 16'd1, 16'd2, 0, "post_rst_add");

        for (int i = 0; i < 60; i++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
            op(c, pick(), pick(), bit'($urandom_range(0, 1)), $sformatf("rnd%0d_c%0h", i, c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
